// File: rtl/neuron_mac_ctrl.sv
// One neuron: streams len weight/activation pairs through a Q16.16 multiplier, saturating-accumulates, adds bias, optional ReLU.
// Latency: done in cycle len+4 after the accepted start (cycle 2 when len==0); start is ignored while busy.

module q16_sat_mul (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_full;
  logic signed [63:0] w_sh;

  always_comb begin
    w_a    = {{32{i_a[31]}}, i_a};
    w_b    = {{32{i_b[31]}}, i_b};
    w_full = w_a * w_b;
    // Truncate toward minus infinity, then clamp into the Q16.16 range.
    w_sh   = w_full >>> 16;
    if (w_sh > 64'sh0000_0000_7FFF_FFFF)
      o_p = 32'h7FFF_FFFF;
    else if (w_sh < -64'sh0000_0000_8000_0000)
      o_p = 32'h8000_0000;
    else
      o_p = w_sh[31:0];
  end
endmodule

module neuron_mac_ctrl #(
  parameter int ADDR_W  = 10,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [31:0]       i_bias,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_w_data,
  input  logic [31:0]       i_x_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_result
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_BIAS, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_len;
  logic [31:0]         r_bias;
  logic [31:0]         r_acc;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_d_vld;
  logic                r_p_vld;
  logic [31:0]         r_prod;
  logic                r_drain;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_result;

  logic [31:0]         w_prod;
  logic [31:0]         w_biased;
  logic [31:0]         w_final;
  logic [ADDR_W-1:0]   w_last;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31]))
      sat_add = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sat_add = s;
  endfunction

  q16_sat_mul u_mul (
    .i_a (i_w_data),
    .i_b (i_x_data),
    .o_p (w_prod)
  );

  assign w_last   = r_len - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_biased = sat_add(r_acc, r_bias);
  assign w_final  = (RELU_EN && w_biased[31]) ? 32'h0000_0000 : w_biased;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_bias    <= '0;
      r_acc     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_d_vld   <= 1'b0;
      r_p_vld   <= 1'b0;
      r_prod    <= '0;
      r_drain   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      // Valid bits follow each element: read -> RAM data -> product -> accumulate.
      r_d_vld <= r_rd_en;
      r_p_vld <= r_d_vld;
      if (r_d_vld) r_prod <= w_prod;
      if (r_p_vld) r_acc <= sat_add(r_acc, r_prod);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len  <= i_len;
            r_bias <= i_bias;
            r_acc  <= '0;
            r_busy <= 1'b1;
            if (i_len != '0) begin
              r_state   <= S_RUN;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end else begin
              r_state <= S_BIAS;
            end
          end
        end
        S_RUN: begin
          if (r_rd_addr == w_last) begin
            r_rd_en <= 1'b0;
            r_drain <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_BIAS;
        end
        S_BIAS: begin
          r_result <= w_final;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
endmodule
